// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control and state holder for an iterative AES-128
// round datapath (IDLE -> RUN for NR+1 rounds -> DONE with ciphertext).
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_block/in_key
// input handshake; dp_state/dp_key/dp_round/dp_first/dp_last drive the
// external round logic and dp_next_state returns its result;
// out_valid/out_ready/out_data output handshake; busy; blk_count.
// Optional macro AES_SEQ_ABORT_EN adds input abort and output aborted.
module aes_round_sequencer #(
    parameter int NR      = 10,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_block,
    input  logic [127:0]       in_key,
    output logic [127:0]       dp_state,
    output logic [127:0]       dp_key,
    output logic [ROUND_W-1:0] dp_round,
    output logic               dp_first,
    output logic               dp_last,
    input  logic [127:0]       dp_next_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic               busy,
    output logic [15:0]        blk_count
`ifdef AES_SEQ_ABORT_EN
    ,
    input  logic               abort,
    output logic               aborted
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NR);

    state_e             state_q, state_d;
    logic [127:0]       dp_state_q, dp_state_d;
    logic [127:0]       dp_key_q, dp_key_d;
    logic [ROUND_W-1:0] dp_round_q, dp_round_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       out_data_q, out_data_d;
    logic [15:0]        blk_count_q, blk_count_d;
    logic               load;
    logic               abort_req;

`ifdef AES_SEQ_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_req = abort;
    assign aborted   = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dp_state_q  <= '0;
            dp_key_q    <= '0;
            dp_round_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            blk_count_q <= '0;
`ifdef AES_SEQ_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dp_state_q  <= dp_state_d;
            dp_key_q    <= dp_key_d;
            dp_round_q  <= dp_round_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            blk_count_q <= blk_count_d;
`ifdef AES_SEQ_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        dp_state_d  = dp_state_q;
        dp_key_d    = dp_key_q;
        dp_round_d  = dp_round_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_count_d = blk_count_q;
        load        = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        aborted_d   = (state_q == RUN) && abort;
`endif
        unique case (state_q)
            IDLE: load = in_valid;
            RUN: begin
                // Abort wins over completion in the same cycle
                if (abort_req) begin
                    state_d    = IDLE;
                    dp_round_d = '0;
                end else begin
                    dp_state_d = dp_next_state;
                    if (dp_round_q == LAST_RND) begin
                        out_data_d  = dp_next_state;
                        out_valid_d = 1'b1;
                        blk_count_d = blk_count_q + 16'd1;
                        dp_round_d  = '0;
                        state_d     = DONE;
                    end else begin
                        dp_round_d = dp_round_q + ROUND_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    // Back-to-back: accept in the handshake cycle
                    load        = in_valid;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            dp_state_d = in_block;
            dp_key_d   = in_key;
            dp_round_d = '0;
            state_d    = RUN;
        end
    end

    // Output decode
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        dp_first = 1'b0;
        dp_last  = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy     = 1'b1;
                dp_first = (dp_round_q == '0);
                dp_last  = (dp_round_q == LAST_RND);
            end
            DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign dp_state  = dp_state_q;
    assign dp_key    = dp_key_q;
    assign dp_round  = dp_round_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed bench for aes_round_sequencer with a
// behavioural AES-128 round datapath closing the loop on dp_next_state.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic [3:0]   dp_round;
    logic         dp_first;
    logic         dp_last;
    logic [127:0] dp_next_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [15:0]  blk_count;
`ifdef AES_SEQ_ABORT_EN
    logic         abort;
    logic         aborted;
`endif

    int tests = 0;
    int fails = 0;
    int seen;

    always #5 clk = ~clk;

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        {w0, w1, w2, w3} = k;
        rc = 8'h01;
        for (int i = 1; i <= r; i++) begin
            t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
            t  = t ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            rc = xt(rc);
        end
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] rnd(input logic [127:0] s,
                                         input logic [127:0] k,
                                         input logic first,
                                         input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        if (first) return s ^ k;
        for (int i = 0; i < 16; i++) b[i] = sb(s[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4 * c];
                a1 = t[4 * c + 1];
                a2 = t[4 * c + 2];
                a3 = t[4 * c + 3];
                t[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = t[i];
        return o ^ k;
    endfunction

    always_comb
        dp_next_state = rnd(dp_state, rkey(dp_key, int'(dp_round)),
                            dp_first, dp_last);

    aes_round_sequencer #(.NR(10), .ROUND_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_block      (in_block),
        .in_key        (in_key),
        .dp_state      (dp_state),
        .dp_key        (dp_key),
        .dp_round      (dp_round),
        .dp_first      (dp_first),
        .dp_last       (dp_last),
        .dp_next_state (dp_next_state),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .blk_count     (blk_count)
`ifdef AES_SEQ_ABORT_EN
        ,
        .abort         (abort),
        .aborted       (aborted)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        in_key    = '0;
        out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) step();

        // Reset state
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_round", 128'(dp_round), 128'(0));
        chk("rst_dp_state", dp_state, 128'h0);
        chk("rst_dp_key", dp_key, 128'h0);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_blk_count", 128'(blk_count), 128'(0));
        chk("rst_first_last", 128'({dp_first, dp_last}), 128'(0));
        rst_n = 1'b1;
        step();

        // FIPS-197 vector, round sequence and latency
        in_block  = PT_A;
        in_key    = KEY_A;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("s1_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        in_block = '0;
        in_key   = '0;
        chk("s1_busy", 128'(busy), 128'(1));
        chk("s1_in_ready_run", 128'(in_ready), 128'(0));
        chk("s1_dp_key", dp_key, KEY_A);
        chk("s1_dp_state", dp_state, PT_A);
        for (int r = 0; r <= 10; r++) begin
            chk("s1_round", 128'(dp_round), 128'(r));
            chk("s1_first", 128'(dp_first), 128'(r == 0));
            chk("s1_last", 128'(dp_last), 128'(r == 10));
            chk("s1_no_valid", 128'(out_valid), 128'(0));
            step();
        end
        chk("s1_out_valid", 128'(out_valid), 128'(1));
        chk("s1_out_data", out_data, CT_A);
        chk("s1_blk_count", 128'(blk_count), 128'(1));
        chk("s1_done_in_ready", 128'(in_ready), 128'(1));
        chk("s1_done_flags", 128'({busy, dp_first, dp_last}), 128'(0));
        step();
        chk("s1_hs_valid", 128'(out_valid), 128'(0));
        chk("s1_idle_ready", 128'(in_ready), 128'(1));
        chk("s1_idle_busy", 128'(busy), 128'(0));
        chk("s1_data_kept", out_data, CT_A);

        // Backpressure
        do_reset();
        in_block = PT_A;
        in_key   = KEY_A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        chk("s2_early_valid", 128'(out_valid), 128'(0));
        step();
        for (int i = 0; i < 20; i++) begin
            chk("s2_hold_valid", 128'(out_valid), 128'(1));
            chk("s2_hold_data", out_data, CT_A);
            chk("s2_hold_ready", 128'(in_ready), 128'(0));
            chk("s2_hold_count", 128'(blk_count), 128'(1));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("s2_ready_comb", 128'(in_ready), 128'(1));
        step();
        chk("s2_hs_valid", 128'(out_valid), 128'(0));
        chk("s2_idle_ready", 128'(in_ready), 128'(1));
        chk("s2_idle_busy", 128'(busy), 128'(0));
        chk("s2_count", 128'(blk_count), 128'(1));

        // Back-to-back
        do_reset();
        out_ready = 1'b1;
        in_block  = PT_A;
        in_key    = KEY_A;
        in_valid  = 1'b1;
        step();
        in_block = PT_B;
        in_key   = KEY_B;
        repeat (5) step();
        chk("s3_held_ready", 128'(in_ready), 128'(0));
        chk("s3_key_a", dp_key, KEY_A);
        repeat (6) step();
        chk("s3_first_valid", 128'(out_valid), 128'(1));
        chk("s3_first_data", out_data, CT_A);
        chk("s3_hs_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        chk("s3_b_valid_low", 128'(out_valid), 128'(0));
        chk("s3_b_busy", 128'(busy), 128'(1));
        chk("s3_b_round", 128'(dp_round), 128'(0));
        chk("s3_b_key", dp_key, KEY_B);
        chk("s3_b_state", dp_state, PT_B);
        repeat (10) step();
        chk("s3_b_early", 128'(out_valid), 128'(0));
        step();
        chk("s3_b_valid", 128'(out_valid), 128'(1));
        chk("s3_b_data", out_data, CT_B);
        chk("s3_count", 128'(blk_count), 128'(2));
        step();

        // Reset mid-RUN
        do_reset();
        out_ready = 1'b1;
        in_block  = PT_A;
        in_key    = KEY_A;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("s4_round5", 128'(dp_round), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("s4_valid", 128'(out_valid), 128'(0));
        chk("s4_round", 128'(dp_round), 128'(0));
        chk("s4_count", 128'(blk_count), 128'(0));
        chk("s4_busy", 128'(busy), 128'(0));
        chk("s4_ready", 128'(in_ready), 128'(1));
        step();
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            step();
            if (out_valid) seen++;
        end
        chk("s4_no_output", 128'(seen), 128'(0));
        chk("s4_ready_after", 128'(in_ready), 128'(1));

        // Key stability with churning inputs
        in_block = PT_A;
        in_key   = KEY_A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            in_block = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("s5_key", dp_key, KEY_A);
        end
        chk("s5_valid", 128'(out_valid), 128'(1));
        chk("s5_data", out_data, CT_A);
        chk("s5_count", 128'(blk_count), 128'(1));
        step();

`ifdef AES_SEQ_ABORT_EN
        // Abort mid-RUN, then a clean transaction
        in_block = PT_A;
        in_key   = KEY_A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("s6_round3", 128'(dp_round), 128'(3));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("s6_aborted", 128'(aborted), 128'(1));
        chk("s6_busy", 128'(busy), 128'(0));
        chk("s6_round", 128'(dp_round), 128'(0));
        chk("s6_ready", 128'(in_ready), 128'(1));
        step();
        chk("s6_aborted_pulse", 128'(aborted), 128'(0));
        seen = 0;
        repeat (12) begin
            if (out_valid) seen++;
            step();
        end
        chk("s6_no_output", 128'(seen), 128'(0));
        chk("s6_count", 128'(blk_count), 128'(1));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (11) step();
        chk("s6_valid", 128'(out_valid), 128'(1));
        chk("s6_data", out_data, CT_A);
        chk("s6_count2", 128'(blk_count), 128'(2));
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control and state-holding block for the iterative AES-128 encryption round datapath.
- Accepts one plaintext/key pair per transaction over a valid/ready handshake.
- Holds the 128-bit cipher state and key stable, and drives round index and first/last selects to the external combinational round logic (key generator, addRoundKey, full round, final round).
- Captures the round result every cycle and presents the ciphertext on a valid/ready output, replacing free-running, reset-less round counting.

Parameters:
- NR, 10, number of cipher rounds after the initial addRoundKey; legal 1..15.
- ROUND_W, 4, width of the round index; must satisfy 2^ROUND_W > NR.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext/key offered
- in_ready  output  1  block can accept a new transaction
- in_block  input  128  plaintext
- in_key  input  128  cipher key
- dp_state  output  128  current cipher state to the round datapath
- dp_key  output  128  captured key to the key generator; held for the whole transaction
- dp_round  output  ROUND_W  round index selecting the round key
- dp_first  output  1  high when dp_round==0: datapath applies addRoundKey only
- dp_last  output  1  high when dp_round==NR: datapath applies subBytes, shiftRows, addRoundKey (no mixColumns)
- dp_next_state  input  128  combinational datapath result for the current round
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  128  ciphertext
- busy  output  1  high in RUN
- blk_count  output  16  completed-transaction counter

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1 once in IDLE (combinational from state).
  - out_valid=0, busy=0, dp_round=0.
  - dp_state, dp_key, out_data, blk_count all 0.
  - Reset mid-RUN or mid-DONE discards the transaction; no out_valid is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready: dp_state<=in_block, dp_key<=in_key, dp_round<=0, go RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: dp_state<=dp_next_state.
  - If dp_round<NR: dp_round<=dp_round+1.
  - If dp_round==NR: out_data<=dp_next_state, out_valid<=1, blk_count<=blk_count+1 (wraps 0xFFFF->0), dp_round<=0, go DONE.
- dp_first and dp_last are decoded from dp_round and asserted only in RUN; both are 0 in IDLE and DONE.
- Latency:
  - Acceptance at edge T gives out_valid=1 after edge T+NR+1 (11 cycles for NR=10).
  - Throughput is one block per NR+2 cycles with out_ready held high.
- DONE:
  - out_valid=1; out_data held stable until out_valid&&out_ready.
  - in_ready = out_ready (combinational), enabling back-to-back transactions.
  - On out_ready: out_valid<=0. If in_valid is also high, capture the new block and go RUN; otherwise go IDLE.
  - out_data keeps its last value after the handshake.
- in_block/in_key changes while not accepted are ignored; dp_key never changes during RUN.
- in_valid held high in RUN is not accepted and is not lost; it is accepted at the first in_ready.

Optional Feature:
- Macro: AES_SEQ_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit) and output aborted (1 bit, registered, reset 0).
  - abort=1 in RUN: next edge goes to IDLE, dp_round<=0, aborted pulses 1 for one cycle, no out_valid, blk_count unchanged.
  - abort in IDLE or DONE is ignored.
  - abort takes priority over NR completion in the same cycle.
- Without the macro: neither port exists and RUN always completes.

Test Plan:
- FIPS-197 vector, bench datapath model: in_block=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f, out_ready=1.
  - Expect out_valid 11 cycles after acceptance, out_data=69c4e0d86a7b0430d8cdb78070b4c55a, blk_count=1.
  - Expect dp_round sequence 0..10, dp_first only at round 0, dp_last only at round 10.
- Backpressure: same vector with out_ready=0 for 20 cycles.
  - Expect out_valid held and out_data stable, in_ready=0, blk_count=1.
  - On out_ready=1: one-cycle handshake, then IDLE.
- Back-to-back: two vectors, in_valid and out_ready held high.
  - Expect the second accepted in the first result's handshake cycle.
  - Expect the second out_valid exactly 12 cycles after the first; blk_count=2.
- Reset mid-RUN: rst_n=0 at dp_round=5.
  - Expect immediate IDLE, out_valid=0, dp_round=0, blk_count=0, in_ready=1 after release.
- Key stability: change in_key and in_block every cycle during RUN.
  - Expect dp_key constant and ciphertext unchanged from the first scenario.
- With AES_SEQ_ABORT_EN: abort at dp_round=3.
  - Expect aborted=1 for one cycle, no out_valid, blk_count unchanged.
  - A following FIPS vector completes correctly.
